// File: rtl/ramb4_rd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ramb4_rd_pkg
// Brief  : Shared constants and state encoding for the RAMB4 S16/S2 reader.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package ramb4_rd_pkg;

  localparam int C_ADDR_W = 8;
  localparam int C_DATA_W = 16;
  localparam int C_SYM_W  = 2;
  localparam int C_R      = C_DATA_W / C_SYM_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ramb4_s16_s2_reader_sym_unpack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sym_unpack
// Brief  : Holding register plus shift register that unpacks words to symbols.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module sym_unpack
  import ramb4_rd_pkg::*;
#(
  parameter int DATA_W    = C_DATA_W,
  parameter int SYM_W     = C_SYM_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_cap,
  input  logic [DATA_W-1:0] i_cap_data,
  input  logic              i_last_word,
  input  logic              i_sym_ready,
  output logic              o_hold_empty,
  output logic              o_word_done,
  output logic [SYM_W-1:0]  o_sym_data,
  output logic              o_sym_valid,
  output logic              o_sym_last
);

  localparam int R     = DATA_W / SYM_W;
  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(R - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shifted;
  logic              r_hold_v;
  logic              r_shift_v;
  logic [IDX_W-1:0]  r_idx;
  logic              w_fire;
  logic              w_word_done;
  logic              w_shift_free;

  assign w_fire       = r_shift_v & i_sym_ready;
  assign w_word_done  = w_fire & (r_idx == C_IDX_LAST);
  assign w_shift_free = ~r_shift_v | w_word_done;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign o_sym_data = r_shift[DATA_W-1 -: SYM_W];
      assign w_shifted  = r_shift << SYM_W;
    end else begin : g_lsb_first
      assign o_sym_data = r_shift[SYM_W-1:0];
      assign w_shifted  = r_shift >> SYM_W;
    end
  endgenerate

  // A returning word bypasses the holding register when the shifter is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_shift   <= '0;
      r_shift_v <= 1'b0;
      r_idx     <= '0;
    end else if (i_flush) begin
      r_hold_v  <= 1'b0;
      r_shift_v <= 1'b0;
      r_idx     <= '0;
    end else begin
      if (w_shift_free && r_hold_v) begin
        r_shift   <= r_hold;
        r_shift_v <= 1'b1;
        r_idx     <= '0;
        r_hold_v  <= 1'b0;
      end else if (w_shift_free && i_cap) begin
        r_shift   <= i_cap_data;
        r_shift_v <= 1'b1;
        r_idx     <= '0;
      end else if (w_shift_free) begin
        r_shift_v <= 1'b0;
        r_idx     <= '0;
      end else if (w_fire) begin
        r_shift <= w_shifted;
        r_idx   <= r_idx + C_IDX_ONE;
      end
      if (i_cap && !(w_shift_free && !r_hold_v)) begin
        r_hold   <= i_cap_data;
        r_hold_v <= 1'b1;
      end
    end
  end

  assign o_hold_empty = ~r_hold_v;
  assign o_word_done  = w_word_done;
  assign o_sym_valid  = r_shift_v;
  assign o_sym_last   = r_shift_v & (r_idx == C_IDX_LAST) & i_last_word;

endmodule
`default_nettype wire

// File: rtl/ramb4_s16_s2_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ramb4_s16_s2_reader
// Brief  : Reads a run of wide RAM words and streams them as narrow symbols.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module ramb4_s16_s2_reader
  import ramb4_rd_pkg::*;
#(
  parameter int ADDR_W    = C_ADDR_W,
  parameter int DATA_W    = C_DATA_W,
  parameter int SYM_W     = C_SYM_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   WORD_CNT,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic              RAM_EN,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [DATA_W-1:0] RAM_DO,
  output logic [SYM_W-1:0]  SYM_DATA,
  output logic              SYM_VALID,
  input  logic              SYM_READY,
  output logic              SYM_LAST
);

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W + 1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W:0]   r_issue_rem;
  logic [ADDR_W:0]   r_words_left;
  logic              r_ram_en;
  logic              r_pend;
  logic              r_done;
  logic              w_busy;
  logic              w_abort;
  logic              w_issue;
  logic              w_start_run;
  logic              w_start_zero;
  logic              w_last_word;
  logic              w_word_done;
  logic              w_hold_empty;
  logic              w_xfer_end;

  assign w_start_run  = (r_state == ST_IDLE) & START & (WORD_CNT != '0);
  assign w_start_zero = (r_state == ST_IDLE) & START & (WORD_CNT == '0);
  assign w_last_word  = (r_words_left == C_CNT_ONE);
  assign w_xfer_end   = w_word_done & w_last_word;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_run) w_state_nxt = ST_RUN;
      ST_RUN:  if (ABORT || w_xfer_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Only one read may be outstanding, and only into an empty holding register.
  always_comb begin
    w_busy  = 1'b0;
    w_abort = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_busy  = 1'b1;
        w_abort = ABORT;
        w_issue = ~ABORT & (r_issue_rem != '0) & ~r_ram_en & ~r_pend & w_hold_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr       <= '0;
      r_ram_addr   <= '0;
      r_issue_rem  <= '0;
      r_words_left <= '0;
      r_ram_en     <= 1'b0;
      r_pend       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_start_zero | (w_busy & ~w_abort & w_xfer_end);
      r_pend <= r_ram_en & ~w_abort;
      if (w_start_run) begin
        r_ram_en     <= 1'b1;
        r_ram_addr   <= BASE_ADDR;
        r_addr       <= BASE_ADDR + C_ADDR_ONE;
        r_issue_rem  <= WORD_CNT - C_CNT_ONE;
        r_words_left <= WORD_CNT;
      end else begin
        r_ram_en <= w_issue;
        if (w_issue) begin
          r_ram_addr  <= r_addr;
          r_addr      <= r_addr + C_ADDR_ONE;
          r_issue_rem <= r_issue_rem - C_CNT_ONE;
        end
        if (w_abort) begin
          r_issue_rem  <= '0;
          r_words_left <= '0;
        end else if (w_word_done) begin
          r_words_left <= r_words_left - C_CNT_ONE;
        end
      end
    end
  end

  sym_unpack #(
    .DATA_W    (DATA_W),
    .SYM_W     (SYM_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_unpack (
    .clk          (CLK),
    .rst_n        (RST_N),
    .i_flush      (w_abort),
    .i_cap        (r_pend),
    .i_cap_data   (RAM_DO),
    .i_last_word  (w_last_word),
    .i_sym_ready  (SYM_READY),
    .o_hold_empty (w_hold_empty),
    .o_word_done  (w_word_done),
    .o_sym_data   (SYM_DATA),
    .o_sym_valid  (SYM_VALID),
    .o_sym_last   (SYM_LAST)
  );

  assign BUSY     = w_busy;
  assign DONE     = r_done;
  assign RAM_EN   = r_ram_en;
  assign RAM_ADDR = r_ram_addr;

endmodule
`default_nettype wire

// File: tb/tb_ramb4_s16_s2_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_ramb4_s16_s2_reader
// Brief  : Directed scoreboard bench for the RAMB4 S16/S2 reader.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_ramb4_s16_s2_reader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  BASE_ADDR = '0;
  logic [8:0]  WORD_CNT = '0;
  logic        ABORT = 1'b0;
  logic        BUSY, DONE, RAM_EN;
  logic [7:0]  RAM_ADDR;
  logic [15:0] RAM_DO;
  logic [1:0]  SYM_DATA;
  logic        SYM_VALID;
  logic        SYM_READY = 1'b0;
  logic        SYM_LAST;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_sym_q[$];
  logic [7:0] exp_addr_q[$];
  logic [15:0] mem [0:255];

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RAM_EN) RAM_DO <= mem[RAM_ADDR];

  ramb4_s16_s2_reader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR),
    .WORD_CNT(WORD_CNT), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
    .RAM_EN(RAM_EN), .RAM_ADDR(RAM_ADDR), .RAM_DO(RAM_DO),
    .SYM_DATA(SYM_DATA), .SYM_VALID(SYM_VALID), .SYM_READY(SYM_READY),
    .SYM_LAST(SYM_LAST)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
  task automatic do_xfer(input logic [7:0] base, input logic [8:0] cnt, input int mode,
                         input bit poke, input bit abort_start, input int budget,
                         output int first_en, output int first_v, output int done_c,
                         output int v_cycles, output int span);
    logic [15:0] d;
    logic [7:0]  a;
    logic [2:0]  e;
    logic        lst;
    logic [1:0]  hd;
    logic        hl;
    bit          stall;
    bit          fin;
    int          reads, dones, hs, last_v;
    for (int w = 0; w < int'(cnt); w++) begin
      a = base + w[7:0];
      exp_addr_q.push_back(a);
      d = mem[a];
      for (int s = 0; s < 8; s++) begin
        lst = (w == int'(cnt) - 1) && (s == 7);
        exp_sym_q.push_back({lst, d[2*s +: 2]});
      end
    end
    first_en = -1; first_v = -1; done_c = -1; v_cycles = 0; last_v = -1;
    reads = 0; dones = 0; hs = 0; stall = 0; fin = 0; hd = '0; hl = 1'b0;
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = base; WORD_CNT = cnt; ABORT = abort_start;
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge CLK);
      START = poke && (c == 6);
      ABORT = 1'b0;
      SYM_READY = (mode == 0) ? 1'b1 : ((c % 4 == 1) || (c % 4 == 0));
      if (c == 1) check("busy_c1", {31'd0, BUSY}, {31'd0, cnt != 0});
      if (RAM_EN) begin
        reads++;
        if (first_en < 0) first_en = c;
        if (exp_addr_q.size() > 0) check("ram_addr", {24'd0, RAM_ADDR}, {24'd0, exp_addr_q.pop_front()});
      end
      if (SYM_VALID) begin
        v_cycles++;
        if (first_v < 0) first_v = c;
        last_v = c;
        if (stall) begin
          check("hold_data", {30'd0, SYM_DATA}, {30'd0, hd});
          check("hold_last", {31'd0, SYM_LAST}, {31'd0, hl});
        end
        if (SYM_READY) begin
          hs++;
          stall = 0;
          if (exp_sym_q.size() > 0) begin
            e = exp_sym_q.pop_front();
            check("sym_data", {30'd0, SYM_DATA}, {30'd0, e[1:0]});
            check("sym_last", {31'd0, SYM_LAST}, {31'd0, e[2]});
          end
        end else begin
          stall = 1; hd = SYM_DATA; hl = SYM_LAST;
        end
      end
      if (DONE) begin
        dones++;
        if (done_c < 0) begin
          done_c = c;
          check("done_busy", {31'd0, BUSY}, 32'd0);
          check("done_valid", {31'd0, SYM_VALID}, 32'd0);
        end
      end
      if (done_c >= 0 && c >= done_c + 3) fin = 1;
    end
    START = 1'b0;
    check("done_seen", {31'd0, done_c >= 0}, 32'd1);
    check("done_count", dones, 1);
    check("reads", reads, int'(cnt));
    check("symbols", hs, 8 * int'(cnt));
    span = (first_v < 0) ? 0 : last_v - first_v + 1;
    exp_sym_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    int fe, fv, dc, vc, sp;
    logic [3:0] seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hE4E4;
    mem[8'h30] = 16'hFFFF;
    mem[8'h31] = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_ram_en", {31'd0, RAM_EN}, 32'd0);
    check("rst_ram_addr", {24'd0, RAM_ADDR}, 32'd0);
    check("rst_valid", {31'd0, SYM_VALID}, 32'd0);
    check("rst_last", {31'd0, SYM_LAST}, 32'd0);
    check("rst_data", {30'd0, SYM_DATA}, 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single word with latency checks
    do_xfer(8'h10, 9'd1, 0, 0, 0, 60, fe, fv, dc, vc, sp);
    check("single_en_cycle", fe, 1);
    check("single_valid_cycle", fv, 3);
    check("single_done_cycle", dc, 11);
    check("single_valid_count", vc, 8);

    // Streaming, with an ignored START while busy
    do_xfer(8'h40, 9'd4, 0, 1, 0, 100, fe, fv, dc, vc, sp);
    check("stream_valid_count", vc, 32);
    check("stream_span", sp, 32);

    // Address wrap
    do_xfer(8'hFE, 9'd3, 0, 0, 0, 100, fe, fv, dc, vc, sp);
    check("wrap_valid_count", vc, 24);

    // Backpressure
    do_xfer(8'h80, 9'd2, 1, 0, 0, 200, fe, fv, dc, vc, sp);

    // Zero count
    do_xfer(8'h00, 9'd0, 0, 0, 0, 20, fe, fv, dc, vc, sp);
    check("zero_done_cycle", dc, 1);
    check("zero_no_read", fe, -1);

    // Full RAM
    do_xfer(8'h00, 9'd256, 0, 0, 0, 3000, fe, fv, dc, vc, sp);
    check("full_valid_count", vc, 2048);
    check("full_span", sp, 2048);

    // Abort with a read in flight
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = 8'h20; WORD_CNT = 9'd3; SYM_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("abort_en_c1", {31'd0, RAM_EN}, 32'd1);
    @(negedge CLK);
    ABORT = 1'b1;
    check("abort_busy_c2", {31'd0, BUSY}, 32'd1);
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_valid", {31'd0, SYM_VALID}, 32'd0);
    check("abort_en", {31'd0, RAM_EN}, 32'd0);
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      seen = seen | {SYM_VALID, DONE, RAM_EN, BUSY};
    end
    check("abort_quiet", {28'd0, seen}, 32'd0);

    // New START with a simultaneous idle ABORT runs normally
    do_xfer(8'h20, 9'd2, 0, 0, 1, 100, fe, fv, dc, vc, sp);
    check("post_abort_valid_count", vc, 16);

    // Asynchronous reset mid-transfer
    @(negedge CLK);
    START = 1'b1; BASE_ADDR = 8'h30; WORD_CNT = 9'd4; SYM_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre_rst_valid", {31'd0, SYM_VALID}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_busy", {31'd0, BUSY}, 32'd0);
    check("arst_ram_en", {31'd0, RAM_EN}, 32'd0);
    check("arst_ram_addr", {24'd0, RAM_ADDR}, 32'd0);
    check("arst_valid", {31'd0, SYM_VALID}, 32'd0);
    check("arst_last", {31'd0, SYM_LAST}, 32'd0);
    check("arst_data", {30'd0, SYM_DATA}, 32'd0);
    check("arst_done", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_busy", {31'd0, BUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
